// File: rtl/rv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rv_mem_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one single-port memory between the core's
//   instruction-fetch port (I, read-only) and its load/store port (D,
//   read/write). Only one transaction may be outstanding at a time. A response
//   timeout protects the core against a memory that never answers: the owner
//   of the hung transaction receives an error response instead.
//
// Ports:
//   clk, rst                 single rising-edge clock, synchronous active-high
//                            reset
//   i_req/i_addr             fetch request, held until i_gnt
//   i_gnt/i_rvalid/i_err     fetch accept, one-cycle response, timeout flag
//   i_rdata                  fetch read data (straight from m_rdata)
//   d_req/d_we/d_be/d_addr/  load/store request, held until d_gnt
//   d_wdata
//   d_gnt/d_rvalid/d_err     load/store accept, one-cycle response, timeout
//   d_rdata                  load data (straight from m_rdata)
//   m_req/m_we/m_be/m_addr/  memory command, muxed from the granted port;
//   m_wdata                  the memory always accepts a command
//   m_rvalid/m_rdata         memory response for reads and write acks
// ----------------------------------------------------------------------------
module rv_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic                    i_err,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic                    d_err,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    m_req,
    output logic                    m_we,
    output logic [DATA_WIDTH/8-1:0] m_be,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic                    m_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_rdata
);

    // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice
    // (at least one bit when TIMEOUT is 1).
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t            state_q, state_d;
    port_t             owner_q, owner_d;
    port_t             last_q, last_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;

    logic rsp_ok;
    logic rsp_timeout;
    logic rsp_done;
    logic issue_ok;
    logic gnt_i;
    logic gnt_d;

    // A transaction finishes either with a real memory response or, if none
    // came, when the wait counter hits its last allowed cycle. The real
    // response wins if both would happen in the same cycle.
    assign rsp_ok      = (state_q == WAIT) && m_rvalid;
    assign rsp_timeout = (state_q == WAIT) && !m_rvalid && (tcnt_q == TCNT_LAST);
    assign rsp_done    = rsp_ok || rsp_timeout;

    // A new command may go out while idle, or in the very cycle the current
    // one completes, which allows back-to-back issue with 1-cycle memory.
    // On a tie, the port that did not win last time gets the grant.
    assign issue_ok = !rst && ((state_q == IDLE) || rsp_done);
    assign gnt_i    = issue_ok && i_req && (!d_req || (last_q == PORT_D));
    assign gnt_d    = issue_ok && d_req && (!i_req || (last_q == PORT_I));

    // State register: reset forgets any outstanding transaction and biases
    // the first tie towards the fetch port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= PORT_I;
            last_q  <= PORT_D;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state and output logic. A grant overrides the return to IDLE so
    // that a completing transaction can be followed immediately by the next.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        tcnt_d   = tcnt_q;
        i_gnt    = gnt_i;
        d_gnt    = gnt_d;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_err    = 1'b0;
        d_err    = 1'b0;
        m_req    = gnt_i || gnt_d;
        m_we     = 1'b0;
        m_be     = '1;
        m_addr   = i_addr;
        m_wdata  = '0;

        if ((state_q == WAIT) && !m_rvalid) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end

        if (rsp_done) begin
            state_d = IDLE;
        end

        if (gnt_i || gnt_d) begin
            state_d = WAIT;
            owner_d = gnt_d ? PORT_D : PORT_I;
            last_d  = gnt_d ? PORT_D : PORT_I;
            tcnt_d  = '0;
        end

        if (!rst && rsp_done) begin
            if (owner_q == PORT_D) begin
                d_rvalid = 1'b1;
                d_err    = rsp_timeout;
            end else begin
                i_rvalid = 1'b1;
                i_err    = rsp_timeout;
            end
        end

        if (gnt_d) begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rv_mem_arbiter
//
// Purpose:
//   Self-checking bench for rv_mem_arbiter. A small memory model answers
//   commands one cycle later with data derived from the address (addr XOR
//   0xA5A50000), can be silenced to emulate a hung memory, and can have a
//   stray response injected. Expected responses are queued when stimulus is
//   issued and a monitor pops and compares them whenever the DUT presents
//   i_rvalid or d_rvalid.
// ----------------------------------------------------------------------------
module tb_rv_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic        port_d;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } rsp_t;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic          i_err;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic          d_err;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic          m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;

    logic          mem_silent;
    logic          mem_inject;
    logic          mem_pend;
    logic [AW-1:0] mem_addr;

    rsp_t sb[$];
    int   pass_cnt;
    int   total_cnt;

    rv_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_rvalid(i_rvalid),
        .i_err   (i_err),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_be    (d_be),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_err   (d_err),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rvalid(m_rvalid),
        .m_rdata (m_rdata)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: one-cycle latency, silenced on demand, plus a way to
    // inject a stray response at any moment.
    always @(posedge clk) begin
        mem_pend <= m_req && !mem_silent;
        mem_addr <= m_addr;
    end
    assign m_rvalid = mem_pend || mem_inject;
    assign m_rdata  = mem_addr ^ 32'hA5A5_0000;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive all request inputs just after a rising edge.
    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] da, input logic [31:0] dw);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dwe;
        d_be    = dbe;
        d_addr  = da;
        d_wdata = dw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushRsp(input logic pd, input logic e, input logic cd, input logic [31:0] dat);
        rsp_t r;
        r.port_d   = pd;
        r.err      = e;
        r.chk_data = cd;
        r.data     = dat;
        sb.push_back(r);
    endtask

    task automatic drain(input string name);
        repeat (4) tick();
        checkOutput(name, sb.size(), 0);
    endtask

    // Monitor: every response the DUT presents must match the oldest queued
    // expectation; a response with nothing queued is a failure.
    always @(negedge clk) begin
        if (i_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                checkOutput("rsp_port", {30'd0, i_rvalid, d_rvalid}, e.port_d ? 32'd1 : 32'd2);
                checkOutput("rsp_err", {31'd0, (e.port_d ? d_err : i_err)}, {31'd0, e.err});
                if (e.chk_data) begin
                    checkOutput("rsp_rdata", e.port_d ? d_rdata : i_rdata, e.data);
                end
            end
        end
    end

    // Safety net against a hung simulation.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        bit seen;
        pass_cnt   = 0;
        total_cnt  = 0;
        mem_silent = 1'b0;
        mem_inject = 1'b0;
        rst        = 1'b1;
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
        repeat (2) tick();

        // Outputs forced low during reset even with both ports requesting.
        @(negedge clk);
        checkOutput("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
        checkOutput("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        checkOutput("rst_m_req", {31'd0, m_req}, 32'd0);
        checkOutput("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);

        // Both held high from reset: grants alternate I,D,... every cycle.
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("rr_i_gnt", {31'd0, i_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rr_d_gnt", {31'd0, d_gnt}, (k % 2 == 0) ? 32'd0 : 32'd1);
            checkOutput("rr_m_addr", m_addr, (k % 2 == 0) ? 32'h200 : 32'h300);
            if (k % 2 == 0) pushRsp(1'b0, 1'b0, 1'b1, 32'hA5A5_0200);
            else            pushRsp(1'b1, 1'b0, 1'b1, 32'hA5A5_0300);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drain("rr_queue_empty");

        // Single fetch after reset, 1-cycle memory.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("f_i_gnt", {31'd0, i_gnt}, 32'd1);
        checkOutput("f_m_req", {31'd0, m_req}, 32'd1);
        checkOutput("f_m_addr", m_addr, 32'h100);
        checkOutput("f_m_we", {31'd0, m_we}, 32'd0);
        checkOutput("f_m_be", {28'd0, m_be}, 32'hF);
        checkOutput("f_m_wdata", m_wdata, 32'h0);
        pushRsp(1'b0, 1'b0, 1'b1, 32'hA5A5_0100);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("f_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        drain("f_queue_empty");

        // Partial store through the D port.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("st_d_gnt", {31'd0, d_gnt}, 32'd1);
        checkOutput("st_i_gnt", {31'd0, i_gnt}, 32'd0);
        checkOutput("st_m_we", {31'd0, m_we}, 32'd1);
        checkOutput("st_m_be", {28'd0, m_be}, 32'h3);
        checkOutput("st_m_addr", m_addr, 32'h20);
        checkOutput("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
        pushRsp(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drain("st_queue_empty");

        // Hung memory: error response exactly 15 cycles after the grant,
        // then a late response in IDLE must be ignored.
        mem_silent = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        @(negedge clk);
        checkOutput("to_d_gnt", {31'd0, d_gnt}, 32'd1);
        pushRsp(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cnt  = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            cnt++;
            if (d_rvalid) seen = 1'b1;
            else tick();
        end
        checkOutput("to_latency", cnt, 32'd15);
        checkOutput("to_d_err", {31'd0, d_err}, 32'd1);
        tick();
        mem_inject = 1'b1;
        @(negedge clk);
        checkOutput("late_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        tick();
        mem_inject = 1'b0;
        drain("to_queue_empty");

        // Reset while waiting: the outstanding response is dropped and the
        // next tie goes to I again.
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("mr_i_gnt", {31'd0, i_gnt}, 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst        = 1'b1;
        mem_inject = 1'b1;
        @(negedge clk);
        checkOutput("mr_rst_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        tick();
        mem_inject = 1'b0;
        tick();
        rst        = 1'b0;
        mem_inject = 1'b1;
        @(negedge clk);
        checkOutput("mr_idle_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        tick();
        mem_inject = 1'b0;
        mem_silent = 1'b0;
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h90, 32'h0);
        @(negedge clk);
        checkOutput("mr_tie_i_gnt", {31'd0, i_gnt}, 32'd1);
        checkOutput("mr_tie_d_gnt", {31'd0, d_gnt}, 32'd0);
        pushRsp(1'b0, 1'b0, 1'b1, 32'hA5A5_0080);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drain("mr_queue_empty");

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
